gate_vector_sequencer: RTL and testbench
========================================

// Module: gate_vector_sequencer
// PURPOSE
//  Exhaustive truth-table stimulus/check stage for small combinational gates (orgate and siblings).
//  Sits around the gate under test: drives its inputs (a,b,...) with every input combination.
//  Holds each vector for a fixed number of cycles, samples the gate output and compares it with a
//  reference of the selected operation. Reports an error count, the first failing vector, and busy/done status.
//  Replaces hand-written #5 stimulus sequences with a synthesizable, self-checking sequencer.
// PARAMETERS
//  N_IN         2   number of gate inputs; vectors 0 .. 2**N_IN-1
//  HOLD_CYCLES  5   cycles each vector is held; legal range 1..255
//  CNT_W        8   width of error counter
// PORTS
//  clk            in   1          single clock; all state updates on rising edge
//  rst            in   1          synchronous, active-high reset
//  start          in   1          pulse/level; sampled only in IDLE or DONE
//  op_sel         in   2          00 OR, 01 AND, 10 XOR, 11 NOR; latched at start
//  vec_o          out  N_IN       stimulus to gate inputs; bit0 -> a, bit1 -> b, ...
//  dut_i          in   1          gate output (c)
//  busy           out  1          1 while sequencing
//  done           out  1          1 after full sweep; sticky until next accepted start or rst
//  err_flag       out  1          1 once any mismatch seen in current run
//  err_cnt        out  CNT_W      mismatch count, saturating at 2**CNT_W-1
//  first_err_vec  out  N_IN       vector of first mismatch; 0 when err_flag=0
// BEHAVIOUR
//  Reset: rst=1 at an edge -> state IDLE; vec_o, busy, done, err_flag, err_cnt, first_err_vec, hold_cnt all 0.
//   Overrides everything, including mid-sweep; no partial result is retained.
//  FSM states: IDLE, DRIVE, DONE.
//   IDLE  -- start=1 -> DRIVE; vec_o=0, hold_cnt=0, busy=1; op latched; err_cnt, err_flag, first_err_vec cleared.
//   DRIVE -- hold_cnt increments each cycle; vec_o stable.
//            At hold_cnt==HOLD_CYCLES-1, that edge samples dut_i and compares it with ref(op, vec_o).
//            Mismatch -> err_cnt+1 (saturating), err_flag=1; first_err_vec loaded only if err_flag was 0.
//            Same edge: if vec_o==2**N_IN-1 -> DONE (busy=0, done=1, vec_o holds last vector);
//            else vec_o+1, hold_cnt=0.
//            start and op_sel are ignored in DRIVE.
//   DONE  -- outputs frozen. start=1 -> same action as from IDLE (done cleared on that edge).
//  Timing: start accepted at edge E0 -> vector k is driven from E(k*H) to E((k+1)*H).
//   Its sample is taken at edge E((k+1)*H). done=1 from edge E(2**N_IN * H); N_IN=2, H=5 -> E20.
//  HOLD_CYCLES=1: one sample per cycle, no idle gap between vectors.
//  Reference model: ref = OR/AND/XOR/NOR reduction of vec_o[N_IN-1:0]. NOR is the inverted OR reduction.
//  hold_cnt width = $clog2(HOLD_CYCLES+1); vector counter width = N_IN+1 so the last-vector test is not hidden by wrap.
// STRUCTURE
//  gate_test_pkg: typedef enum {OP_OR, OP_AND, OP_XOR, OP_NOR} gate_op_t (2 bits);
//   typedef enum {S_IDLE, S_DRIVE, S_DONE} seq_state_t.
//  Sub-module gate_ref_model: combinational, params N_IN; ports op, vec -> exp. Also reusable by benches.
//  Top holds FSM, hold counter, vector counter, error accumulator.
// TESTING (N_IN=2, HOLD_CYCLES=5, CNT_W=8 unless stated; dut = orgate on vec_o)
//  1. rst 2 cycles, start pulse, op=OR, real orgate -> vec_o 00,01,10,11 for 5 cycles each; done=1 at E20;
//     err_cnt=0, err_flag=0.
//  2. dut_i tied 0, op=OR -> err_cnt=3, err_flag=1, first_err_vec=01, done at E20.
//  3. orgate driven with op=AND -> mismatches at 01 and 10 -> err_cnt=2, first_err_vec=01.
//  4. rst at E8 mid-sweep -> next edge all outputs 0, IDLE; new start gives clean sweep, err_cnt=0.
//  5. start held high and op_sel toggled during DRIVE -> no restart; result as in 1.
//     start in DONE -> new sweep, done cleared.
//  6. CNT_W=1, HOLD_CYCLES=1, dut_i tied 0, op=OR -> err_cnt saturates at 1; done at E4.

Source files
------------

// File: rtl/gate_vector_sequencer_pkg.sv
// Shared types for the exhaustive gate truth-table sequencer and its reference model.
// Operation encoding matches the op_sel field seen on the bus.
package gate_test_pkg;

   typedef enum logic [1:0] {
      OP_OR  = 2'b00,
      OP_AND = 2'b01,
      OP_XOR = 2'b10,
      OP_NOR = 2'b11
   } gate_op_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DRIVE,
      S_DONE
   } seq_state_t;

endpackage

// File: rtl/gate_vector_sequencer_if.sv
// Control, status and gate-side signals of the truth-table sequencer.
// slave is the sequencer; master is whoever starts it and owns the gate under test.
interface gate_vector_sequencer_if
   import gate_test_pkg::*;
#(
   parameter int N_IN  = 2,
   parameter int CNT_W = 8
);

   logic              start;
   gate_op_t          op_sel;
   logic [N_IN-1:0]   vec_o;
   logic              dut_i;
   logic              busy;
   logic              done;
   logic              err_flag;
   logic [CNT_W-1:0]  err_cnt;
   logic [N_IN-1:0]   first_err_vec;

   modport master (
      output start, op_sel, dut_i,
      input  vec_o, busy, done, err_flag, err_cnt, first_err_vec
   );

   modport slave (
      input  start, op_sel, dut_i,
      output vec_o, busy, done, err_flag, err_cnt, first_err_vec
   );

endinterface

// File: rtl/gate_vector_sequencer_ref_model.sv
// Combinational golden reference: reduction of the input vector by the selected operation.
// Kept separate so benches can reuse the same reference.
module gate_ref_model
   import gate_test_pkg::*;
#(
   parameter int N_IN = 2
) (
   input  gate_op_t        op,
   input  logic [N_IN-1:0] vec,
   output logic            exp
);

   always_comb begin
      exp = 1'b0;
      case (op)
         OP_OR:  exp = |vec;
         OP_AND: exp = &vec;
         OP_XOR: exp = ^vec;
         OP_NOR: exp = ~(|vec);
      endcase
   end

endmodule

// File: rtl/gate_vector_sequencer.sv
// Walks every input vector of a small gate, holds each for HOLD_CYCLES, and compares the
// gate output against the reference at the end of each hold, accumulating error status.
module gate_vector_sequencer
   import gate_test_pkg::*;
#(
   parameter int N_IN        = 2,
   parameter int HOLD_CYCLES = 5,
   parameter int CNT_W       = 8
) (
   input logic                    clk,
   input logic                    rst,
   gate_vector_sequencer_if.slave bus
);

   localparam int HW = $clog2(HOLD_CYCLES + 1);
   // One extra vector-counter bit so the last-vector compare never aliases through wrap.
   localparam int VW = N_IN + 1;

   localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD_CYCLES - 1);
   localparam logic [VW-1:0]    VEC_LAST  = VW'((1 << N_IN) - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

   seq_state_t        state;
   gate_op_t          op_q;
   logic [HW-1:0]     hold_cnt;
   logic [VW-1:0]     vec_cnt;
   logic              busy_q;
   logic              done_q;
   logic              err_flag_q;
   logic [CNT_W-1:0]  err_cnt_q;
   logic [N_IN-1:0]   first_err_q;
   logic              ref_bit;

   gate_ref_model #(.N_IN(N_IN)) u_ref (
      .op  (op_q),
      .vec (vec_cnt[N_IN-1:0]),
      .exp (ref_bit)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         op_q        <= OP_OR;
         hold_cnt    <= '0;
         vec_cnt     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_flag_q  <= 1'b0;
         err_cnt_q   <= '0;
         first_err_q <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (bus.start) begin
                  state       <= S_DRIVE;
                  op_q        <= bus.op_sel;
                  hold_cnt    <= '0;
                  vec_cnt     <= '0;
                  busy_q      <= 1'b1;
                  done_q      <= 1'b0;
                  err_flag_q  <= 1'b0;
                  err_cnt_q   <= '0;
                  first_err_q <= '0;
               end
            end
            S_DRIVE: begin
               if (hold_cnt == HOLD_LAST) begin
                  if (bus.dut_i != ref_bit) begin
                     if (err_cnt_q != CNT_MAX) begin
                        err_cnt_q <= err_cnt_q + CNT_W'(1);
                     end
                     err_flag_q <= 1'b1;
                     if (!err_flag_q) begin
                        first_err_q <= vec_cnt[N_IN-1:0];
                     end
                  end
                  hold_cnt <= '0;
                  if (vec_cnt == VEC_LAST) begin
                     state  <= S_DONE;
                     busy_q <= 1'b0;
                     done_q <= 1'b1;
                  end else begin
                     vec_cnt <= vec_cnt + VW'(1);
                  end
               end else begin
                  hold_cnt <= hold_cnt + HW'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.vec_o         = vec_cnt[N_IN-1:0];
   assign bus.busy          = busy_q;
   assign bus.done          = done_q;
   assign bus.err_flag      = err_flag_q;
   assign bus.err_cnt       = err_cnt_q;
   assign bus.first_err_vec = first_err_q;

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// Directed bench: an orgate (or a stuck-at-0 output) around the sequencer, with expected
// vectors and end-of-sweep results queued at start and compared as the sweep plays out.
module tb_gate_vector_sequencer;
   import gate_test_pkg::*;

   localparam int H = 5;

   typedef struct {
      logic [7:0] cnt;
      logic       flag;
      logic [1:0] first;
   } res_t;

   logic clk = 1'b0;
   logic rst;
   logic rst_b;
   bit   tie_zero;

   logic [1:0] vec_q[$];
   res_t       res_q[$];
   int         pass_cnt = 0;
   int         total    = 0;

   always #5 clk = ~clk;

   gate_vector_sequencer_if #(.N_IN(2), .CNT_W(8)) ifa ();
   gate_vector_sequencer_if #(.N_IN(2), .CNT_W(1)) ifb ();

   assign ifa.dut_i = tie_zero ? 1'b0 : (ifa.vec_o[0] | ifa.vec_o[1]);
   assign ifb.dut_i = 1'b0;

   gate_vector_sequencer #(.N_IN(2), .HOLD_CYCLES(H), .CNT_W(8)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa)
   );

   gate_vector_sequencer #(.N_IN(2), .HOLD_CYCLES(1), .CNT_W(1)) dut_b (
      .clk (clk),
      .rst (rst_b),
      .bus (ifb)
   );

   function automatic bit model_ref(gate_op_t op, logic [1:0] v);
      case (op)
         OP_OR:   return v[0] | v[1];
         OP_AND:  return v[0] & v[1];
         OP_XOR:  return v[0] ^ v[1];
         default: return !(v[0] | v[1]);
      endcase
   endfunction

   task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      total++;
      assert (obs === exp_v) pass_cnt++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
   endtask

   // Push the vector sequence and the end-of-sweep result the orgate/stuck-0 source should give.
   task automatic predict(input gate_op_t op, input bit zero);
      res_t r;
      int   errs = 0;
      r.flag  = 1'b0;
      r.first = 2'b00;
      for (int k = 0; k < 4; k++) begin
         logic [1:0] v;
         bit         got;
         v   = 2'(k);
         got = zero ? 1'b0 : (v[0] | v[1]);
         vec_q.push_back(v);
         if (got != model_ref(op, v)) begin
            if (!r.flag) r.first = v;
            r.flag = 1'b1;
            errs++;
         end
      end
      r.cnt = (errs > 255) ? 8'hFF : 8'(errs);
      res_q.push_back(r);
   endtask

   task automatic apply_stimulus(input gate_op_t op, input bit zero, input bit hold_start);
      res_t r;
      @(negedge clk);
      tie_zero   = zero;
      ifa.op_sel = op;
      ifa.start  = 1'b1;
      predict(op, zero);
      for (int n = 1; n <= 4 * H; n++) begin
         @(negedge clk);
         if (hold_start) ifa.op_sel = gate_op_t'(n[1:0]);
         else            ifa.start  = 1'b0;
         check_output("vec_o", 8'(ifa.vec_o), 8'(vec_q[0]));
         check_output("busy", 8'(ifa.busy), 8'd1);
         check_output("done_early", 8'(ifa.done), 8'd0);
         if (n % H == 0) void'(vec_q.pop_front());
      end
      @(negedge clk);
      ifa.start = 1'b0;
      r = res_q.pop_front();
      check_output("done", 8'(ifa.done), 8'd1);
      check_output("busy_end", 8'(ifa.busy), 8'd0);
      check_output("vec_last", 8'(ifa.vec_o), 8'd3);
      check_output("err_cnt", ifa.err_cnt, r.cnt);
      check_output("err_flag", 8'(ifa.err_flag), 8'(r.flag));
      check_output("first_err_vec", 8'(ifa.first_err_vec), 8'(r.first));
   endtask

   initial begin
      rst        = 1'b1;
      rst_b      = 1'b1;
      tie_zero   = 1'b0;
      ifa.start  = 1'b0;
      ifa.op_sel = OP_OR;
      ifb.start  = 1'b0;
      ifb.op_sel = OP_OR;
      repeat (2) @(negedge clk);
      check_output("rst_vec", 8'(ifa.vec_o), 8'd0);
      check_output("rst_busy", 8'(ifa.busy), 8'd0);
      check_output("rst_done", 8'(ifa.done), 8'd0);
      check_output("rst_err_cnt", ifa.err_cnt, 8'd0);
      check_output("rst_err_flag", 8'(ifa.err_flag), 8'd0);
      rst   = 1'b0;
      rst_b = 1'b0;

      apply_stimulus(OP_OR, 1'b0, 1'b0);
      apply_stimulus(OP_OR, 1'b1, 1'b0);
      apply_stimulus(OP_AND, 1'b0, 1'b0);
      apply_stimulus(OP_XOR, 1'b0, 1'b0);
      apply_stimulus(OP_NOR, 1'b1, 1'b0);

      // Reset landing at E8, after one mismatch has already been recorded.
      @(negedge clk);
      tie_zero   = 1'b1;
      ifa.op_sel = OP_NOR;
      ifa.start  = 1'b1;
      @(negedge clk);
      ifa.start = 1'b0;
      repeat (7) @(negedge clk);
      check_output("pre_rst_err_cnt", ifa.err_cnt, 8'd1);
      rst = 1'b1;
      @(negedge clk);
      check_output("mid_rst_vec", 8'(ifa.vec_o), 8'd0);
      check_output("mid_rst_busy", 8'(ifa.busy), 8'd0);
      check_output("mid_rst_done", 8'(ifa.done), 8'd0);
      check_output("mid_rst_err_cnt", ifa.err_cnt, 8'd0);
      check_output("mid_rst_err_flag", 8'(ifa.err_flag), 8'd0);
      check_output("mid_rst_first", 8'(ifa.first_err_vec), 8'd0);
      rst = 1'b0;
      apply_stimulus(OP_OR, 1'b0, 1'b0);

      // start held and op_sel churned during the sweep, then a fresh start out of DONE.
      apply_stimulus(OP_OR, 1'b0, 1'b1);
      apply_stimulus(OP_AND, 1'b0, 1'b0);

      // One-cycle hold with a 1-bit saturating counter.
      @(negedge clk);
      ifb.op_sel = OP_OR;
      ifb.start  = 1'b1;
      for (int n = 1; n <= 4; n++) begin
         @(negedge clk);
         ifb.start = 1'b0;
         check_output("b_vec", 8'(ifb.vec_o), 8'(n - 1));
         check_output("b_busy", 8'(ifb.busy), 8'd1);
      end
      @(negedge clk);
      check_output("b_done", 8'(ifb.done), 8'd1);
      check_output("b_err_cnt_sat", 8'(ifb.err_cnt), 8'd1);
      check_output("b_err_flag", 8'(ifb.err_flag), 8'd1);
      check_output("b_first_err_vec", 8'(ifb.first_err_vec), 8'd1);

      $display("[TB] %0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
